// File: rtl/jtag_cmd_ctrl_pkg.sv
// Shared definitions for the JTAG command sequencer.
// Contents: IR instruction codes, flag bit positions, FSM state encodings,
//           and a helper that classifies instructions needing a memory access.
package jtag_cmd_ctrl_pkg;

   localparam int IR_LENGTH = 4;

   // Instruction register codes
   localparam logic [IR_LENGTH-1:0] IIDENT = 4'h0;
   localparam logic [IR_LENGTH-1:0] IRADDR = 4'h1;
   localparam logic [IR_LENGTH-1:0] IWADDR = 4'h2;
   localparam logic [IR_LENGTH-1:0] IWDATA = 4'h3;
   localparam logic [IR_LENGTH-1:0] IRDATA = 4'h4;
   localparam logic [IR_LENGTH-1:0] IUART  = 4'h5;
   localparam logic [IR_LENGTH-1:0] IFLAGS = 4'h6;

   // Flag bits that act as one-cycle UART strobes instead of persistent flags
   localparam int FLAG_UTX  = 21;
   localparam int FLAG_UTXM = 22;
   localparam int FLAG_UTXB = 23;

   localparam logic [31:0] FLAG_STROBE_MASK =
      (32'd1 << FLAG_UTX) | (32'd1 << FLAG_UTXM) | (32'd1 << FLAG_UTXB);

   // FSM state encodings
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WRITE    = 2'd1;
   localparam logic [1:0] ST_PREFETCH = 2'd2;

   // Instructions that start a memory access and therefore need the FSM idle
   function automatic logic is_mem_cmd(input logic [IR_LENGTH-1:0] code);
      return (code == IRADDR) || (code == IRDATA) || (code == IWDATA);
   endfunction

endpackage

// File: rtl/jtag_cmd_ctrl.sv
// Command sequencer between the virtual-JTAG TAP and the system-clock datapath.
// Ports: clk_50_/reset (sync, active-high); ir selects cap_data; cmd_valid/cmd_ir/cmd_data
//        carry completed DR scans; mem_* is a req/ack single-word port; uart_*/flags/busy/overrun status.
module jtag_cmd_ctrl
   import jtag_cmd_ctrl_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] IDENT_VALUE = 32'h4A54_4731
) (
   input  logic                  clk_50_,
   input  logic                  reset,
   input  logic [IR_LENGTH-1:0]  ir,
   input  logic                  cmd_valid,
   input  logic [IR_LENGTH-1:0]  cmd_ir,
   input  logic [31:0]           cmd_data,
   output logic [31:0]           cap_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic [7:0]            uart_data,
   output logic                  uart_tx,
   output logic                  uart_txm,
   output logic                  uart_txb,
   output logic [31:0]           flags,
   output logic                  busy,
   output logic [7:0]            overrun
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [31:0]           rd_buf;
   logic [ADDR_WIDTH-1:0] raddr_next;

   assign busy       = (state != ST_IDLE);
   assign raddr_next = raddr + ADDR_ONE;

   always_ff @(posedge clk_50_) begin
      if (reset) begin
         state     <= ST_IDLE;
         raddr     <= '0;
         waddr     <= '0;
         rd_buf    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         uart_data <= '0;
         uart_tx   <= 1'b0;
         uart_txm  <= 1'b0;
         uart_txb  <= 1'b0;
         flags     <= '0;
         overrun   <= '0;
      end else begin
         uart_tx  <= 1'b0;
         uart_txm <= 1'b0;
         uart_txb <= 1'b0;

         // Complete the outstanding access. mem_req is high in every non-idle
         // state, so an ack seen here is always a real acceptance.
         case (state)
            ST_WRITE: begin
               if (mem_ack) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  waddr   <= waddr + ADDR_ONE;
               end
            end
            ST_PREFETCH: begin
               if (mem_ack) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
                  rd_buf  <= mem_rdata;
               end
            end
            default: ;
         endcase

         if (cmd_valid) begin
            if (is_mem_cmd(cmd_ir) && (state != ST_IDLE)) begin
               // Dropped: no pointer update, only the saturating count moves
               if (overrun != 8'hFF)
                  overrun <= overrun + 8'd1;
            end else begin
               // Memory commands below are only reached from IDLE. An IWADDR
               // landing on a write ack overrides the increment, as the host's
               // explicit address is the newer intent.
               case (cmd_ir)
                  IRADDR: begin
                     raddr    <= cmd_data[ADDR_WIDTH-1:0];
                     mem_addr <= cmd_data[ADDR_WIDTH-1:0];
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     state    <= ST_PREFETCH;
                  end
                  IRDATA: begin
                     raddr    <= raddr_next;
                     mem_addr <= raddr_next;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     state    <= ST_PREFETCH;
                  end
                  IWDATA: begin
                     mem_addr  <= waddr;
                     mem_wdata <= cmd_data;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     state     <= ST_WRITE;
                  end
                  IWADDR: waddr <= cmd_data[ADDR_WIDTH-1:0];
                  IUART:  uart_data <= cmd_data[7:0];
                  IFLAGS: begin
                     flags    <= cmd_data & ~FLAG_STROBE_MASK;
                     uart_tx  <= cmd_data[FLAG_UTX];
                     uart_txm <= cmd_data[FLAG_UTXM];
                     uart_txb <= cmd_data[FLAG_UTXB];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Capture word for the next DR scan, selected by the live instruction
   always_comb begin
      cap_data = '0;
      case (ir)
         IIDENT: cap_data = IDENT_VALUE;
         IRDATA: cap_data = rd_buf;
         IRADDR: cap_data = 32'(raddr);
         IWADDR: cap_data = 32'(waddr);
         IFLAGS: cap_data = flags;
         default: cap_data = '0;
      endcase
   end

endmodule

// File: tb/tb_jtag_cmd_ctrl.sv
module tb_jtag_cmd_ctrl;
   import jtag_cmd_ctrl_pkg::*;

   logic        clk_50_ = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  ir = 4'h0;
   logic        cmd_valid = 1'b0;
   logic [3:0]  cmd_ir = 4'h0;
   logic [31:0] cmd_data = 32'h0;
   logic [31:0] cap_data;
   logic        mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [7:0]  uart_data;
   logic        uart_tx, uart_txm, uart_txb;
   logic [31:0] flags;
   logic        busy;
   logic [7:0]  overrun;

   int checks = 0;
   int errors = 0;

   // memory responder state
   int          ack_delay = 0;
   bit          ack_hold = 1'b0;
   int          wait_cnt = 0;
   int          req_cycles = 0;
   int          wr_count = 0;
   logic [9:0]  last_wr_addr = 10'h0;
   logic [31:0] last_wr_data = 32'h0;
   logic [31:0] mem_model [0:1023];

   jtag_cmd_ctrl dut (
      .clk_50_(clk_50_), .reset(reset), .ir(ir),
      .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
      .cap_data(cap_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .uart_data(uart_data), .uart_tx(uart_tx), .uart_txm(uart_txm), .uart_txb(uart_txb),
      .flags(flags), .busy(busy), .overrun(overrun)
   );

   always #10 clk_50_ = ~clk_50_;

   // Acks after ack_delay cycles of mem_req, unless held off
   always @(negedge clk_50_) begin
      if (mem_req) begin
         req_cycles++;
         if (!ack_hold && wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_model[mem_addr];
         end else begin
            mem_ack = 1'b0;
         end
         wait_cnt++;
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(posedge clk_50_) begin
      if (mem_req && mem_ack && mem_we) begin
         wr_count++;
         last_wr_addr = mem_addr;
         last_wr_data = mem_wdata;
      end
   end

   task automatic send_cmd(input logic [3:0] code, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_ir    = code;
      cmd_data  = data;
      @(negedge clk_50_);
      cmd_valid = 1'b0;
      cmd_data  = 32'h0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_50_);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk_50_);
      reset = 1'b0;
      ir = IIDENT; #1;
      checks++; if (cap_data !== 32'h4A54_4731) begin errors++; $display("FAIL ident_cap got %h exp 4a544731", cap_data); end
      checks++; if ({mem_req, mem_we, busy, uart_tx, uart_txm, uart_txb} !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", {mem_req, mem_we, busy, uart_tx, uart_txm, uart_txb}); end
      checks++; if ({flags, uart_data, overrun} !== 48'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {flags, uart_data, overrun}); end
      ir = IRDATA; #1;
      checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL reset_rdbuf got %h exp 0", cap_data); end
      ir = 4'hF; #1;
      checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL undef_cap got %h exp 0", cap_data); end
      @(negedge clk_50_);
   endtask

   task automatic test_write;
      bit ok;
      ack_delay = 3;
      send_cmd(IWADDR, 32'h5);
      ir = IWADDR; #1;
      checks++; if (cap_data !== 32'h5) begin errors++; $display("FAIL waddr_cap got %h exp 5", cap_data); end
      @(negedge clk_50_);
      req_cycles = 0;
      send_cmd(IWDATA, 32'hE000_0000);
      checks++; if ({mem_req, mem_we, busy} !== 3'b111) begin errors++; $display("FAIL wr_req got %b exp 111", {mem_req, mem_we, busy}); end
      checks++; if (mem_addr !== 10'd5 || mem_wdata !== 32'hE000_0000) begin errors++; $display("FAIL wr_addr_data got %h/%h exp 005/e0000000", mem_addr, mem_wdata); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_timeout busy=%b exp 0", busy); end
      checks++; if (wr_count !== 1 || last_wr_addr !== 10'd5 || last_wr_data !== 32'hE000_0000) begin errors++; $display("FAIL wr_log got n=%0d %h/%h exp 1 005/e0000000", wr_count, last_wr_addr, last_wr_data); end
      checks++; if (req_cycles !== 4) begin errors++; $display("FAIL wr_req_len got %0d exp 4", req_cycles); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop got %b exp 0", mem_req); end
      ir = IWADDR; #1;
      checks++; if (cap_data !== 32'h6) begin errors++; $display("FAIL waddr_inc got %h exp 6", cap_data); end
      @(negedge clk_50_);
   endtask

   task automatic test_read;
      bit ok;
      ack_delay = 1;
      send_cmd(IRADDR, 32'h3FF);
      checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 10'h3FF) begin errors++; $display("FAIL rd_req got %b %h exp 10 3ff", {mem_req, mem_we}, mem_addr); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rd_timeout busy=%b exp 0", busy); end
      ir = IRDATA; #1;
      checks++; if (cap_data !== 32'hAAAA_0001) begin errors++; $display("FAIL rdbuf_a got %h exp aaaa0001", cap_data); end
      ir = IRADDR; #1;
      checks++; if (cap_data !== 32'h3FF) begin errors++; $display("FAIL raddr_cap got %h exp 3ff", cap_data); end
      @(negedge clk_50_);
      send_cmd(IRDATA, 32'hFFFF_FFFF);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h000) begin errors++; $display("FAIL rd_wrap got %b %h exp 1 000", mem_req, mem_addr); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rd2_timeout busy=%b exp 0", busy); end
      ir = IRDATA; #1;
      checks++; if (cap_data !== 32'hBBBB_0002) begin errors++; $display("FAIL rdbuf_b got %h exp bbbb0002", cap_data); end
      ir = IRADDR; #1;
      checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL raddr_wrap got %h exp 0", cap_data); end
      @(negedge clk_50_);
   endtask

   task automatic test_back_to_back;
      bit ok;
      int base;
      base = wr_count;
      ack_hold = 1'b1;
      send_cmd(IWDATA, 32'h1111_1111);
      send_cmd(IWDATA, 32'h2222_2222);
      checks++; if (overrun !== 8'd1) begin errors++; $display("FAIL ovr_one got %0d exp 1", overrun); end
      send_cmd(IUART, 32'h55);
      checks++; if (uart_data !== 8'h55 || overrun !== 8'd1) begin errors++; $display("FAIL uart_busy got %h ovr %0d exp 55 1", uart_data, overrun); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 10'd6 || mem_wdata !== 32'h1111_1111) begin errors++; $display("FAIL wr_hold got %b %h %h exp 1 006 11111111", mem_req, mem_addr, mem_wdata); end
      ack_hold = 1'b0;
      ack_delay = 0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout busy=%b exp 0", busy); end
      checks++; if (wr_count - base !== 1 || last_wr_data !== 32'h1111_1111) begin errors++; $display("FAIL b2b_log got n=%0d %h exp 1 11111111", wr_count - base, last_wr_data); end
      ir = IWADDR; #1;
      checks++; if (cap_data !== 32'h7) begin errors++; $display("FAIL b2b_waddr got %h exp 7", cap_data); end
      @(negedge clk_50_);
      // memory command landing in the ack cycle is dropped
      ack_delay = 1;
      send_cmd(IWDATA, 32'h3333_3333);
      @(negedge clk_50_);
      send_cmd(IWDATA, 32'h4444_4444);
      checks++; if (busy !== 1'b0 || overrun !== 8'd2) begin errors++; $display("FAIL ack_cycle_drop got busy %b ovr %0d exp 0 2", busy, overrun); end
      checks++; if (wr_count - base !== 2 || last_wr_data !== 32'h3333_3333) begin errors++; $display("FAIL ack_cycle_log got n=%0d %h exp 2 33333333", wr_count - base, last_wr_data); end
      ir = IWADDR; #1;
      checks++; if (cap_data !== 32'h8) begin errors++; $display("FAIL ack_cycle_waddr got %h exp 8", cap_data); end
      @(negedge clk_50_);
   endtask

   task automatic test_uart_flags;
      send_cmd(IUART, 32'h1AA);
      checks++; if (uart_data !== 8'hAA) begin errors++; $display("FAIL uart_data got %h exp aa", uart_data); end
      send_cmd(IFLAGS, 32'h0080_0001);
      checks++; if ({uart_tx, uart_txm, uart_txb} !== 3'b001) begin errors++; $display("FAIL txb_pulse got %b exp 001", {uart_tx, uart_txm, uart_txb}); end
      checks++; if (flags !== 32'h1) begin errors++; $display("FAIL flags_val got %h exp 00000001", flags); end
      ir = IFLAGS; #1;
      checks++; if (cap_data !== 32'h1) begin errors++; $display("FAIL flags_cap got %h exp 00000001", cap_data); end
      @(negedge clk_50_);
      checks++; if ({uart_tx, uart_txm, uart_txb} !== 3'b000) begin errors++; $display("FAIL txb_end got %b exp 000", {uart_tx, uart_txm, uart_txb}); end
      // back-to-back: each command its own pulse, all set bits together
      send_cmd(IFLAGS, 32'h0060_0100);
      checks++; if ({uart_tx, uart_txm, uart_txb} !== 3'b110 || flags !== 32'h100) begin errors++; $display("FAIL b2b_flags1 got %b %h exp 110 00000100", {uart_tx, uart_txm, uart_txb}, flags); end
      send_cmd(IFLAGS, 32'h0020_0000);
      checks++; if ({uart_tx, uart_txm, uart_txb} !== 3'b100 || flags !== 32'h0) begin errors++; $display("FAIL b2b_flags2 got %b %h exp 100 0", {uart_tx, uart_txm, uart_txb}, flags); end
      @(negedge clk_50_);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", uart_tx); end
      send_cmd(IFLAGS, 32'h0000_00F0);
      send_cmd(4'hF, 32'hFFFF_FFFF);
      checks++; if (flags !== 32'hF0 || busy !== 1'b0 || uart_data !== 8'hAA) begin errors++; $display("FAIL undef_cmd got %h %b %h exp f0 0 aa", flags, busy, uart_data); end
   endtask

   task automatic test_reset_mid;
      int base;
      base = wr_count;
      ack_hold = 1'b1;
      send_cmd(IWDATA, 32'h5555_0005);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
      reset = 1'b1;
      @(negedge clk_50_);
      reset = 1'b0;
      checks++; if ({mem_req, mem_we, busy} !== 3'b000) begin errors++; $display("FAIL mid_reset got %b exp 000", {mem_req, mem_we, busy}); end
      ir = IWADDR; #1;
      checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL mid_waddr got %h exp 0", cap_data); end
      checks++; if (wr_count !== base || overrun !== 8'd0 || flags !== 32'h0) begin errors++; $display("FAIL mid_state got n=%0d ovr %0d fl %h exp %0d 0 0", wr_count, overrun, flags, base); end
      @(negedge clk_50_);
   endtask

   task automatic test_saturate;
      send_cmd(IRDATA, 32'h0);
      cmd_valid = 1'b1;
      cmd_ir = IRDATA;
      repeat (300) @(negedge clk_50_);
      cmd_valid = 1'b0;
      checks++; if (overrun !== 8'd255) begin errors++; $display("FAIL ovr_sat got %0d exp 255", overrun); end
      checks++; if (mem_addr !== 10'd1 || busy !== 1'b1) begin errors++; $display("FAIL sat_ptr got %h %b exp 001 1", mem_addr, busy); end
      ir = IRADDR; #1;
      checks++; if (cap_data !== 32'h1) begin errors++; $display("FAIL sat_raddr got %h exp 1", cap_data); end
      @(negedge clk_50_);
      reset = 1'b1;
      @(negedge clk_50_);
      reset = 1'b0;
      ack_hold = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
      mem_model[1023] = 32'hAAAA_0001;
      mem_model[0]    = 32'hBBBB_0002;
      @(negedge clk_50_);
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_uart_flags();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jtag_cmd_ctrl.md
# jtag_cmd_ctrl

Command sequencer between the virtual-JTAG TAP and the system-clock datapath. It takes completed DR scans, already crossed into the `clk_50_` domain, as one-cycle command strobes. It decodes the instruction register, keeps auto-incrementing read and write address pointers, and sequences single-word accesses to the shared debug memory over a req/ack handshake. It also supplies the capture word for the next DR scan and drives the UART data and strobes and the flags register.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: memory word-address width; pointers wrap modulo 2^ADDR_WIDTH.
- `IDENT_VALUE`, 32'h4A54_4731: word returned for `IIDENT` capture.

Ports:
- `clk_50_`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ir`  in  `IR_LENGTH`  current instruction, synchronized; selects `cap_data`.
- `cmd_valid`  in  1  one-cycle pulse per synchronized `update_dr`.
- `cmd_ir`  in  `IR_LENGTH`  instruction in force at that update.
- `cmd_data`  in  32  shifted DR value, LSB shifted first.
- `cap_data`  out  32  word to load at the next `capture_dr`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  `ADDR_WIDTH`  word address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  request accepted; for reads, `mem_rdata` is valid this cycle.
- `mem_rdata`  in  32  read data.
- `uart_data`  out  8  UART byte.
- `uart_tx`, `uart_txm`, `uart_txb`  out  1 each  one-cycle strobes.
- `flags`  out  32  persistent flag bits.
- `busy`  out  1  FSM not in IDLE.
- `overrun`  out  8  saturating count of dropped commands.

## Operation
- FSM states: IDLE, WRITE, PREFETCH.
- `IIDENT`: no action.
- `IRADDR`: `raddr <= cmd_data[ADDR_WIDTH-1:0]`, then go to PREFETCH.
- `IWADDR`: `waddr <= cmd_data[ADDR_WIDTH-1:0]`.
- `IWDATA`: latch `mem_wdata <= cmd_data` and `mem_addr <= waddr`, go to WRITE. When `mem_ack` arrives, `waddr` increments and wraps.
- `IRDATA`: `raddr` increments and wraps, then go to PREFETCH. TDI data is ignored. The scan just completed captured `rd_buf`, which held the word at the old `raddr`.
- PREFETCH: `mem_req=1`, `mem_we=0`, `mem_addr=raddr`. On ack, `rd_buf <= mem_rdata` and return to IDLE.
- WRITE: `mem_req=1`, `mem_we=1`. On ack, return to IDLE.
- `IUART`: `uart_data <= cmd_data[7:0]`.
- `IFLAGS`: `flags <= cmd_data` with bits 23:21 forced to 0. Bit 21 pulses `uart_tx`, bit 22 pulses `uart_txm`, bit 23 pulses `uart_txb`. All set bits pulse together.
- Undefined IR codes: ignored, no state change.
- `cap_data` is combinational on `ir`:
  - `IIDENT` → `IDENT_VALUE`
  - `IRDATA` → `rd_buf`
  - `IRADDR` → zero-extended `raddr`
  - `IWADDR` → zero-extended `waddr`
  - `IFLAGS` → `flags`
  - otherwise → 0
- Commands that cause no memory access (`IIDENT`, `IWADDR`, `IUART`, `IFLAGS`) execute even while busy.
- A memory command (`IRADDR`, `IRDATA`, `IWDATA`) arriving while busy is dropped entirely, including its pointer update, and `overrun` increments, saturating at 255.

## Timing
- Reset values: all outputs 0 (`mem_req`, `mem_we`, strobes, `flags`, `uart_data`, `overrun`, `busy`); `raddr`, `waddr`, `rd_buf` are 0; FSM in IDLE. `cap_data` follows `ir` with `rd_buf`=0.
- `cmd_valid` in cycle N: registers update at the N→N+1 edge. `mem_req` and strobes are high in cycle N+1.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered and held stable until the cycle in which `mem_ack` is sampled high. `mem_req` is low the following cycle.
- `mem_ack` in the first request cycle is legal: minimum busy time is 1 cycle.
- `mem_ack` while `mem_req` is low is ignored.
- IDLE with `cmd_valid` accepts the command in the same cycle. The FSM completing (ack) in cycle N cannot accept a memory command in cycle N; it counts as overrun.
- `reset` mid-transaction: `mem_req` drops on the next cycle and pointers clear. The memory side must tolerate an abandoned request.
- Strobes last exactly one cycle, even if `IFLAGS` is repeated back-to-back (each command gives its own pulse).

## Structure
- IR codes (`IIDENT`, `IRADDR`, `IWADDR`, `IWDATA`, `IRDATA`, `IUART`, `IFLAGS`) and `IR_LENGTH` come from shared `defines.v`.
- Add to `defines.v`: `FLAG_UTX`=21, `FLAG_UTXM`=22, `FLAG_UTXB`=23, and the FSM state encodings.
- Single module, no sub-modules. The `capture_dr`/`update_dr` synchronizer stays in `system.v`.

## Test plan
- Reset, then `ir`=`IIDENT` → `cap_data`=32'h4A54_4731; all outputs 0.
- `IWADDR` 5, then `IWDATA` 0xE0000000 with ack delayed 3 cycles → one write at addr 5 with data 0xE0000000, `mem_req` high exactly 4 cycles; `IWADDR` capture then reads 6.
- `IRADDR` 0x3FF (memory holds A at 0x3FF, B at 0) → prefetch addr 0x3FF, `rd_buf`=A; `IRDATA` → prefetch addr 0 (wrap), `rd_buf`=B.
- `IWDATA` held unacked, second `IWDATA` arrives → exactly one write issued, `overrun`=1, `waddr` advances once.
- `IUART` 0x1AA then `IFLAGS` 0x00800001 → `uart_data`=0xAA, `uart_txb` high 1 cycle, `uart_tx`/`uart_txm` stay low, `flags`=0x00000001.
- `reset` asserted during WRITE → `mem_req` low next cycle, `busy`=0, `waddr`=0.
